// File: rtl/mbox_pkg.sv
`default_nettype none
// Mailbox register map and the word-offset decoder used by every port.
package mbox_pkg;

  localparam int         MBOX_WORDS_MAX = 8;
  localparam logic [7:0] DOORBELL       = 8'h20;
  localparam logic [7:0] IRQ_CLR        = 8'h24;
  localparam logic [7:0] STATUS         = 8'h28;
  localparam logic [7:0] LAST_SENDER    = 8'h2C;

  typedef enum logic [2:0] {
    REG_MSG,
    REG_DOORBELL,
    REG_IRQ_CLR,
    REG_STATUS,
    REG_LAST_SENDER,
    REG_NONE
  } reg_sel_e;

  // off is addr[7:2]; anything above bit 7 aliases onto the same map.
  function automatic reg_sel_e decode(input logic [5:0] off, input logic [5:0] words);
    reg_sel_e sel;
    sel = REG_NONE;
    if (off < words)                 sel = REG_MSG;
    else if (off == DOORBELL[7:2])    sel = REG_DOORBELL;
    else if (off == IRQ_CLR[7:2])     sel = REG_IRQ_CLR;
    else if (off == STATUS[7:2])      sel = REG_STATUS;
    else if (off == LAST_SENDER[7:2]) sel = REG_LAST_SENDER;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_pkg.sv
`default_nettype none
// OBI request/response bundles shared by the mailbox and its harts.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage
`default_nettype wire

// File: rtl/obi_mailbox_resp_if.sv
`default_nettype none
// Per-hart OBI request/response bundle between the harts and the mailbox.
interface obi_mailbox_resp_if #(
  parameter int NPORTS = 2
);
  import obi_pkg::*;

  obi_req_t  [NPORTS-1:0] slave_req_i;
  obi_resp_t [NPORTS-1:0] slave_resp_o;

  modport master (output slave_req_i, input  slave_resp_o);
  modport slave  (input  slave_req_i, output slave_resp_o);

endinterface
`default_nettype wire

// File: rtl/mbox_rr_arbiter.sv
`default_nettype none
// Two-way round-robin arbiter for same-word MSG write conflicts.
module mbox_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       conflict,
  output logic [1:0] gnt
);

  logic ptr;

  // ptr names the port that wins the next conflict.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= 1'b0;
    end else if (conflict) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    gnt = req;
    if (conflict) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_mailbox_resp.sv
`default_nettype none
// Two-hart OBI mailbox: shared MSG words, doorbell interrupts, status readback.
// Define MBOX_BYTE_WRITE_EN to honour byte enables on MSG writes.
module obi_mailbox_resp
  import obi_pkg::*;
  import mbox_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int MBOX_WORDS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  obi_mailbox_resp_if.slave        bus,
  output logic [NPORTS-1:0]        irq_o
);

  localparam int         WORDS  = (MBOX_WORDS > MBOX_WORDS_MAX) ? MBOX_WORDS_MAX : MBOX_WORDS;
  localparam int         IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [5:0] WORDS6 = 6'(WORDS);

  obi_req_t  [NPORTS-1:0]            req_v;
  obi_resp_t [NPORTS-1:0]            resp;
  reg_sel_e  [NPORTS-1:0]            sel;
  logic      [NPORTS-1:0][IDX_W-1:0] idx;
  logic      [NPORTS-1:0][31:0]      rd_data;
  logic      [NPORTS-1:0][31:0]      rdata_q;
  logic      [NPORTS-1:0]            req, msg_wr_req, gnt_arb, gnt;
  logic      [NPORTS-1:0]            wr_msg, ring, clr, set;
  logic      [NPORTS-1:0]            rvalid_q, pending, unused_bits;
  logic                              last_sender, conflict;
  logic      [31:0]                  mem [WORDS];

  assign req_v = bus.slave_req_i;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign sel[p]         = decode(req_v[p].addr[7:2], WORDS6);
    assign idx[p]         = req_v[p].addr[2 +: IDX_W];
    assign req[p]         = req_v[p].req;
    assign msg_wr_req[p]  = req_v[p].req & req_v[p].we & (sel[p] == REG_MSG);
    assign wr_msg[p]      = gnt[p] & req_v[p].we & (sel[p] == REG_MSG);
    assign ring[p]        = gnt[p] & req_v[p].we & (sel[p] == REG_DOORBELL);
    assign clr[p]         = gnt[p] & req_v[p].we & (sel[p] == REG_IRQ_CLR) & req_v[p].wdata[0];
    assign set[p]         = ring[NPORTS-1-p];
    assign unused_bits[p] = ^{req_v[p].addr[31:8], req_v[p].addr[1:0], req_v[p].be};
  end

  assign conflict = msg_wr_req[0] & msg_wr_req[1] & (idx[0] == idx[1]);

  mbox_rr_arbiter u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req      (req),
    .conflict (conflict),
    .gnt      (gnt_arb)
  );

  assign gnt = gnt_arb & {NPORTS{rst_ni}};

  // Read data comes from pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!req_v[p].we) begin
        case (sel[p])
          REG_MSG:         rd_data[p] = mem[idx[p]];
          REG_STATUS:      rd_data[p] = {30'b0, pending[NPORTS-1-p], pending[p]};
          REG_LAST_SENDER: rd_data[p] = {31'b0, last_sender};
          default:         rd_data[p] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int w = 0; w < WORDS; w++) begin
        mem[w] <= '0;
      end
      pending     <= '0;
      last_sender <= 1'b0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        rvalid_q[p] <= gnt[p];
        rdata_q[p]  <= gnt[p] ? rd_data[p] : 32'h0;
        if (wr_msg[p]) begin
`ifdef MBOX_BYTE_WRITE_EN
          for (int b = 0; b < 4; b++) begin
            if (req_v[p].be[b]) begin
              mem[idx[p]][8*b +: 8] <= req_v[p].wdata[8*b +: 8];
            end
          end
`else
          mem[idx[p]] <= req_v[p].wdata;
`endif
        end
        // Simultaneous doorbells record port 1 as the sender.
        if (ring[p]) begin
          last_sender <= 1'(p);
        end
      end
      pending <= (pending & ~clr) | set;
    end
  end

  always_comb begin
    resp = '0;
    for (int p = 0; p < NPORTS; p++) begin
      resp[p].gnt    = gnt[p];
      resp[p].rvalid = rvalid_q[p] & rst_ni;
      resp[p].rdata  = (rvalid_q[p] & rst_ni) ? rdata_q[p] : 32'h0;
    end
  end

  assign bus.slave_resp_o = resp;
  assign irq_o            = pending & {NPORTS{rst_ni}};

endmodule
`default_nettype wire

// File: tb/tb_obi_mailbox_resp.sv
`default_nettype none
// Directed and randomized checks of obi_mailbox_resp against a register-map model.
module tb_obi_mailbox_resp;
  import obi_pkg::*;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     irq;
  obi_req_t [1:0] drv   = '0;
  int             checks = 0;
  int             errors = 0;

  // Reference model: mailbox contents and expected responses.
  logic [31:0] m_mem [8];
  logic [1:0]  m_pend = '0;
  logic        m_last = 1'b0;
  int          m_turn = 0;
  logic [1:0]  e_rv   = '0;
  logic [31:0] e_rd [2];

  obi_mailbox_resp_if #(.NPORTS(2)) bus ();
  assign bus.slave_req_i = drv;

  obi_mailbox_resp #(.NPORTS(2), .MBOX_WORDS(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic put(input int p, input logic r, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] be);
    drv[p].req   = r;
    drv[p].addr  = a;
    drv[p].we    = w;
    drv[p].wdata = d;
    drv[p].be    = be;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a;
    int k;
    k = $urandom_range(0, 13);
    if (k < 12)       a = 32'(k * 4);
    else if (k == 12) a = 32'h30;
    else              a = 32'hFC;
    a = a | ($urandom & 32'hFFFF_FF03);
    put(p, ($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
  endtask

  // One clock: check outputs mid-cycle, advance the model, return just after the edge.
  task automatic cycle();
    logic [1:0]  eg, nrv, set, clr;
    logic [31:0] nrd [2];
    logic [31:0] mask;
    int          o [2];
    bit          conflict;
    @(negedge clk);
    for (int p = 0; p < 2; p++) o[p] = int'(drv[p].addr[7:2]);
    eg = rst_n ? {drv[1].req, drv[0].req} : 2'b00;
    conflict = eg[0] && eg[1] && drv[0].we && drv[1].we && (o[0] < 8) && (o[0] == o[1]);
    if (conflict) eg[1 - m_turn] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("gnt%0d", p), 32'(bus.slave_resp_o[p].gnt), 32'(eg[p]));
      chk($sformatf("rvalid%0d", p), 32'(bus.slave_resp_o[p].rvalid), 32'(e_rv[p] & rst_n));
      chk($sformatf("rdata%0d", p), bus.slave_resp_o[p].rdata, (e_rv[p] && rst_n) ? e_rd[p] : 32'h0);
      chk($sformatf("irq%0d", p), 32'(irq[p]), 32'(m_pend[p] & rst_n));
    end
    nrv = '0;
    nrd = '{32'h0, 32'h0};
    set = '0;
    clr = '0;
    if (!rst_n) begin
      for (int w = 0; w < 8; w++) m_mem[w] = '0;
      m_pend = '0;
      m_last = 1'b0;
      m_turn = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          nrv[p] = 1'b1;
          if (!drv[p].we) begin
            if (o[p] < 8)        nrd[p] = m_mem[o[p]];
            else if (o[p] == 10) nrd[p] = {30'b0, m_pend[1-p], m_pend[p]};
            else if (o[p] == 11) nrd[p] = {31'b0, m_last};
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (eg[p] && drv[p].we) begin
          if (o[p] < 8) begin
`ifdef MBOX_BYTE_WRITE_EN
            mask = {{8{drv[p].be[3]}}, {8{drv[p].be[2]}}, {8{drv[p].be[1]}}, {8{drv[p].be[0]}}};
`else
            mask = 32'hFFFF_FFFF;
`endif
            m_mem[o[p]] = (m_mem[o[p]] & ~mask) | (drv[p].wdata & mask);
          end else if (o[p] == 8) begin
            set[1-p] = 1'b1;
            m_last   = 1'(p);
          end else if (o[p] == 9 && drv[p].wdata[0]) begin
            clr[p] = 1'b1;
          end
        end
      end
      m_pend = (m_pend & ~clr) | set;
      if (conflict) m_turn = 1 - m_turn;
    end
    @(posedge clk);
    #1;
    e_rv = nrv;
    e_rd = nrd;
  endtask

  initial begin
    for (int w = 0; w < 8; w++) m_mem[w] = '0;
    e_rd = '{32'h0, 32'h0};

    // Reset: outputs stay quiet even with a request present.
    cycle();
    put(0, 1'b1, 32'h0, 1'b1, 32'h1234_5678, 4'hF);
    #1;
    chk("rst_gnt0", 32'(bus.slave_resp_o[0].gnt), 32'h0);
    cycle();
    drv = '0;
    rst_n = 1'b1;
    cycle();

    // Write then read back MSG[2].
    put(0, 1'b1, 32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF);
    cycle();
    drv = '0;
    put(1, 1'b1, 32'h08, 1'b0, 32'h0, 4'h0);
    #1;
    chk("msg_rd_gnt", 32'(bus.slave_resp_o[1].gnt), 32'h1);
    cycle();
    drv = '0;
    chk("msg_rd_rvalid", 32'(bus.slave_resp_o[1].rvalid), 32'h1);
    chk("msg_rd_data", bus.slave_resp_o[1].rdata, 32'hDEAD_BEEF);

    // Same-word write conflict: port 0 first, port 1 next cycle.
    put(0, 1'b1, 32'h04, 1'b1, 32'h11, 4'hF);
    put(1, 1'b1, 32'h04, 1'b1, 32'h22, 4'hF);
    #1;
    chk("cfl_gnt0", 32'(bus.slave_resp_o[0].gnt), 32'h1);
    chk("cfl_gnt1", 32'(bus.slave_resp_o[1].gnt), 32'h0);
    cycle();
    put(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk("cfl_gnt1_later", 32'(bus.slave_resp_o[1].gnt), 32'h1);
    cycle();
    drv = '0;
    put(0, 1'b1, 32'h04, 1'b0, 32'h0, 4'h0);
    cycle();
    drv = '0;
    chk("cfl_final", bus.slave_resp_o[0].rdata, 32'h22);

    // Doorbell from port 1 to port 0, status, sender, clear.
    put(1, 1'b1, 32'h20, 1'b1, 32'h0, 4'hF);
    cycle();
    drv = '0;
    chk("bell_irq0", 32'(irq[0]), 32'h1);
    put(0, 1'b1, 32'h28, 1'b0, 32'h0, 4'h0);
    cycle();
    chk("bell_status", bus.slave_resp_o[0].rdata, 32'h1);
    put(0, 1'b1, 32'h2C, 1'b0, 32'h0, 4'h0);
    cycle();
    chk("bell_sender", bus.slave_resp_o[0].rdata, 32'h1);
    put(0, 1'b1, 32'h24, 1'b1, 32'h1, 4'hF);
    cycle();
    drv = '0;
    chk("bell_clr", 32'(irq[0]), 32'h0);

    // Set beats clear in the same cycle.
    put(1, 1'b1, 32'h20, 1'b1, 32'h0, 4'hF);
    cycle();
    put(0, 1'b1, 32'h24, 1'b1, 32'h1, 4'hF);
    cycle();
    drv = '0;
    chk("set_wins", 32'(irq[0]), 32'h1);
    put(0, 1'b1, 32'h24, 1'b1, 32'h1, 4'hF);
    cycle();
    drv = '0;

    // Byte-enable handling.
    put(0, 1'b1, 32'h0C, 1'b1, 32'hFFFF_FFFF, 4'hF);
    cycle();
    put(0, 1'b1, 32'h0C, 1'b1, 32'h0, 4'b0010);
    cycle();
    put(0, 1'b1, 32'h0C, 1'b0, 32'h0, 4'h0);
    cycle();
    drv = '0;
`ifdef MBOX_BYTE_WRITE_EN
    chk("byte_en", bus.slave_resp_o[0].rdata, 32'hFFFF_00FF);
`else
    chk("byte_en", bus.slave_resp_o[0].rdata, 32'h0);
`endif

    // Reset right after a grant drops the response and clears MSG.
    put(0, 1'b1, 32'h14, 1'b1, 32'h5555_5555, 4'hF);
    cycle();
    put(0, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0);
    cycle();
    drv = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_in", 32'(bus.slave_resp_o[0].rvalid), 32'h0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_drop_after", 32'(bus.slave_resp_o[0].rvalid), 32'h0);
    for (int w = 0; w < 8; w++) begin
      put(0, 1'b1, 32'(w * 4), 1'b0, 32'h0, 4'h0);
      cycle();
      drv = '0;
      chk($sformatf("rst_msg%0d", w), bus.slave_resp_o[0].rdata, 32'h0);
    end

    // Randomized traffic with occasional reset, biased toward collisions.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      rand_req(0);
      rand_req(1);
      if ($urandom_range(0, 2) == 0) begin
        drv[1].addr = drv[0].addr;
        drv[1].we   = drv[0].we;
      end
      cycle();
    end
    rst_n = 1'b1;
    drv = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_mailbox_resp.md
OBI_MAILBOX_RESP -- requirements
Module: obi_mailbox_resp

Interface
REQ-001 The block SHALL have parameter NPORTS, default 2, meaning the number of OBI responder ports, one per hart, fixed at 2.
REQ-002 The block SHALL have parameter MBOX_WORDS, default 8, meaning the number of 32-bit shared message words (power of 2, 1..8).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port slave_req_i, input, obi_req_t [NPORTS-1:0]: OBI requests (req, addr, we, be, wdata) from each hart.
REQ-006 The block SHALL have port slave_resp_o, output, obi_resp_t [NPORTS-1:0]: OBI responses (gnt, rvalid, rdata).
REQ-007 The block SHALL have port irq_o, output, [NPORTS-1:0]: doorbell interrupt per hart, level, fed to a fast-irq line.

Function
REQ-008 Decode SHALL use addr[7:2] (word offset) only: 0x00..(MBOX_WORDS*4-4) MSG words; 0x20 DOORBELL; 0x24 IRQ_CLR; 0x28 STATUS; 0x2C LAST_SENDER; all other offsets unmapped.
REQ-009 gnt[p] SHALL be combinational: asserted in any cycle with req[p]=1 unless p loses arbitration (REQ-012).
REQ-010 For each granted request, rvalid[p] SHALL be asserted exactly one cycle after the grant, for one cycle; rdata is valid only while rvalid=1, else 0.
REQ-011 Back-to-back grants on one port SHALL be supported: one response per cycle, in order, with no stall cycles.
REQ-012 A conflict is both ports writing the same MSG word in the same cycle; a round-robin pointer SHALL grant one port and hold the other with gnt=0. The pointer flips after each conflict resolution; its reset value favours port 0.
REQ-013 On a same-cycle read and write to the same word, the read SHALL return the pre-write value.
REQ-014 A write to DOORBELL from port p SHALL set pending[1-p] and record LAST_SENDER=p; the wdata is ignored.
REQ-015 A write to IRQ_CLR from port p with wdata[0]=1 SHALL clear pending[p].
REQ-016 If a set and a clear of the same pending bit occur in the same cycle, the set SHALL win.
REQ-017 irq_o[p] SHALL equal the registered pending[p], visible the cycle after the DOORBELL grant.
REQ-018 A STATUS read by port p SHALL return {30'b0, pending[1-p], pending[p]}.
REQ-019 LAST_SENDER reads SHALL return {31'b0, last_sender}.
REQ-020 Reads of DOORBELL, IRQ_CLR and unmapped offsets SHALL return 0; writes to them are ignored but still granted and acknowledged with rvalid.

Reset
REQ-021 While rst_ni=0 at a clock edge, all MSG words, pending, last_sender, the arbitration pointer and the response valid flags SHALL clear to 0.
REQ-022 During reset, gnt, rvalid, rdata and irq_o SHALL be 0.
REQ-023 A response pending when reset asserts SHALL be dropped and not emitted after reset.

Configuration
REQ-024 With MBOX_BYTE_WRITE_EN defined, MSG writes SHALL update only the bytes whose be bit is 1.
REQ-025 Without MBOX_BYTE_WRITE_EN, be SHALL be ignored and MSG writes SHALL update the full word.

Structure
REQ-026 Package mbox_pkg SHALL hold the offset constants (DOORBELL, IRQ_CLR, STATUS, LAST_SENDER) and MBOX_WORDS_MAX=8; obi_req_t and obi_resp_t come from obi_pkg.
REQ-027 The conflict arbiter SHALL be a sub-module, mbox_rr_arbiter (2 requests, pointer register, grant vector).

Verification
REQ-028 Port 0 writes MSG[2]=0xDEADBEEF, then port 1 reads offset 0x08 -> gnt in the same cycle; rvalid next cycle with rdata=0xDEADBEEF.
REQ-029 Both ports write MSG[1] in the same cycle (0x11, 0x22), held, after reset -> port 0 granted first and port 1 one cycle later; final read returns 0x22.
REQ-030 Port 1 writes DOORBELL -> irq_o[0]=1 the next cycle; port 0 STATUS read returns 0x1 and LAST_SENDER returns 0x1; port 0 writes IRQ_CLR=1 -> irq_o[0]=0.
REQ-031 In the same cycle, port 1 writes DOORBELL and port 0 writes IRQ_CLR -> irq_o[0] stays 1.
REQ-032 With MBOX_BYTE_WRITE_EN, write 0xFFFFFFFF and then be=4'b0010 with wdata=0x00000000 -> read returns 0xFFFF00FF; without the macro -> read returns 0x00000000.
REQ-033 Assert rst_ni=0 in the cycle after a grant -> no rvalid is emitted, and all MSG reads return 0 after reset.
